// File: rtl/delay_scheduler.sv
// Round-robin arbiter that shares one delay unit among NUM_REQ requesters,
// launching each granted run, waiting for done (or a watchdog abort) and acking the owner.
module delay_scheduler #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned COUNTER_WIDTH = 10,
    parameter int unsigned TIMEOUT_SLACK = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*COUNTER_WIDTH-1:0] req_max,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               ack,
    output logic                             err,
    output logic                             busy,
    output logic                             dly_start,
    output logic [COUNTER_WIDTH-1:0]         dly_max,
    input  logic                             dly_done
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W  = COUNTER_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  ptr;
    logic [WD_W-1:0]   watchdog;

    logic              win_found_c;
    logic [IDX_W-1:0]  win_idx_c;
    logic [WD_W-1:0]   limit_c;
    logic              timeout_c;
    logic              done_c;

    // Rotating priority search starting just after the last owner.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = ptr;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            int cand;
            cand = int'(ptr) + k;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            if (!win_found_c && req[cand]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(cand);
            end
        end
    end

    // Limit is formed one bit wider than the count so max + slack never wraps.
    always_comb begin
        limit_c   = {1'b0, dly_max} + WD_W'(TIMEOUT_SLACK);
        timeout_c = (watchdog == limit_c);
        // A done seen in the first WAIT cycle may be left over from the previous run.
        done_c    = dly_done && (watchdog != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            watchdog  <= '0;
            grant     <= '0;
            ack       <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            dly_start <= 1'b0;
            dly_max   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found_c) begin
                        idx       <= win_idx_c;
                        dly_max   <= req_max[win_idx_c*COUNTER_WIDTH +: COUNTER_WIDTH];
                        grant     <= NUM_REQ'(1) << win_idx_c;
                        dly_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    dly_start <= 1'b0;
                    watchdog  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    watchdog <= watchdog + WD_W'(1);
                    if (done_c) begin
                        ack   <= grant;
                        err   <= 1'b0;
                        state <= RELEASE;
                    end else if (timeout_c) begin
                        ack   <= grant;
                        err   <= 1'b1;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    ack   <= '0;
                    err   <= 1'b0;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= idx;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler with a small delay-unit model that
// raises done a programmable number of cycles after the start pulse.
module tb_delay_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned CW = 10;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*CW-1:0] req_max;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    ack;
    logic             err;
    logic             busy;
    logic             dly_start;
    logic [CW-1:0]    dly_max;
    logic             dly_done;

    int checks;
    int errors;
    int model_d;
    int mcnt;

    delay_scheduler #(
        .NUM_REQ      (NR),
        .COUNTER_WIDTH(CW),
        .TIMEOUT_SLACK(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_max  (req_max),
        .grant    (grant),
        .ack      (ack),
        .err      (err),
        .busy     (busy),
        .dly_start(dly_start),
        .dly_max  (dly_max),
        .dly_done (dly_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay-unit model: done is high only in cycle launch+model_d (0 = never).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt     <= 0;
            dly_done <= 1'b0;
        end else if (dly_start) begin
            mcnt     <= 1;
            dly_done <= (model_d == 1);
        end else if (mcnt > 0) begin
            mcnt     <= mcnt + 1;
            dly_done <= (model_d != 0) && (mcnt + 1 == model_d);
        end
    end

    task automatic do_reset();
        rst     = 1'b0;
        req     = '0;
        req_max = '0;
        model_d = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_max(input int i, input logic [CW-1:0] v);
        req_max[i*CW +: CW] = v;
    endtask

    // Called at the LAUNCH-cycle negedge; counts cycles until ack is seen.
    task automatic wait_ack(input int budget, output int cycles, output logic [NR-1:0] a,
                            output logic e, output logic [CW-1:0] dm, output int starts);
        cycles = -1;
        a      = '0;
        e      = 1'b0;
        dm     = '0;
        starts = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (dly_start) starts++;
            if (ack != '0) begin
                cycles = c;
                a      = ack;
                e      = err;
                dm     = dly_max;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc; logic [NR-1:0] a; logic e; logic [CW-1:0] dm; int st;
        do_reset();
        checks++; if ({grant, ack, err, busy, dly_start} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %b, expected 0", {grant, ack, err, busy, dly_start});
        end
        checks++; if (dly_max !== '0) begin
            errors++; $display("FAIL reset_dly_max: got %0d, expected 0", dly_max);
        end
        set_max(0, 10'd5);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (grant !== '0 || ack !== '0) begin
            errors++; $display("FAIL async_reset_grant_ack: got grant=%b ack=%b, expected 0", grant, ack);
        end
        checks++; if (busy !== 1'b0 || dly_start !== 1'b0) begin
            errors++; $display("FAIL async_reset_busy: got busy=%b start=%b, expected 0", busy, dly_start);
        end
        @(negedge clk);
        checks++; if (ack !== '0) begin
            errors++; $display("FAIL async_reset_no_ack: got %b, expected 0", ack);
        end
        for (int i = 0; i < int'(NR); i++) set_max(i, 10'd3);
        model_d = 5;
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin
            errors++; $display("FAIL post_reset_first_grant: got %b, expected 0001", grant);
        end
        req = '0;
        wait_ack(40, cyc, a, e, dm, st);
        checks++; if (a !== 4'b0001 || cyc != 6) begin
            errors++; $display("FAIL post_reset_ack: got ack=%b cycles=%0d, expected 0001 at 6", a, cyc);
        end
    endtask

    task automatic test_single();
        int cyc; logic [NR-1:0] a; logic e; logic [CW-1:0] dm; int st;
        do_reset();
        set_max(2, 10'd5);
        model_d = 7;
        req = 4'b0100;
        @(negedge clk);
        checks++; if (grant !== 4'b0100 || dly_start !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_launch: got grant=%b start=%b busy=%b, expected 0100 1 1", grant, dly_start, busy);
        end
        checks++; if (dly_max !== 10'd5) begin
            errors++; $display("FAIL single_dly_max: got %0d, expected 5", dly_max);
        end
        req = '0;
        wait_ack(50, cyc, a, e, dm, st);
        checks++; if (st != 0) begin
            errors++; $display("FAIL single_start_pulse: got %0d extra start cycles, expected 0", st);
        end
        checks++; if (a !== 4'b0100 || e !== 1'b0 || cyc != 8) begin
            errors++; $display("FAIL single_ack: got ack=%b err=%b cycles=%0d, expected 0100 0 8", a, e, cyc);
        end
        @(negedge clk);
        checks++; if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release: got ack=%b grant=%b busy=%b, expected 0 0 0", ack, grant, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [NR-1:0] a; logic e; logic [CW-1:0] dm; int st;
        int order [5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] exp_g;
        do_reset();
        for (int i = 0; i < int'(NR); i++) set_max(i, 10'd3);
        model_d = 5;
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            exp_g = NR'(1) << order[r];
            if (r > 0) begin
                @(negedge clk);
                checks++; if (grant !== '0 || busy !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle_gap run%0d: got grant=%b busy=%b, expected 0 0", r, grant, busy);
                end
            end
            @(negedge clk);
            checks++; if (grant !== exp_g || dly_start !== 1'b1) begin
                errors++; $display("FAIL b2b_grant run%0d: got %b start=%b, expected %b 1", r, grant, dly_start, exp_g);
            end
            wait_ack(40, cyc, a, e, dm, st);
            checks++; if (a !== exp_g || cyc != 6 || e !== 1'b0) begin
                errors++; $display("FAIL b2b_ack run%0d: got %b at %0d err=%b, expected %b at 6 err=0", r, a, cyc, e, exp_g);
            end
        end
        req = '0;
        @(negedge clk);
        checks++; if (ack !== '0) begin
            errors++; $display("FAIL b2b_single_ack: got %b, expected 0", ack);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc; logic [NR-1:0] a; logic e; logic [CW-1:0] dm; int st;
        do_reset();
        set_max(0, 10'd10);
        model_d = 0;
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        wait_ack(60, cyc, a, e, dm, st);
        checks++; if (a !== 4'b0001 || e !== 1'b1 || cyc != 20) begin
            errors++; $display("FAIL timeout_ack: got ack=%b err=%b cycles=%0d, expected 0001 1 20", a, e, cyc);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || err !== 1'b0 || ack !== '0) begin
            errors++; $display("FAIL timeout_release: got busy=%b err=%b ack=%b, expected 0 0 0", busy, err, ack);
        end
    endtask

    task automatic test_done_at_timeout();
        int cyc; logic [NR-1:0] a; logic e; logic [CW-1:0] dm; int st;
        do_reset();
        set_max(1, 10'd4);
        model_d = 13;
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        wait_ack(60, cyc, a, e, dm, st);
        checks++; if (a !== 4'b0010 || e !== 1'b0 || cyc != 14) begin
            errors++; $display("FAIL done_wins: got ack=%b err=%b cycles=%0d, expected 0010 0 14", a, e, cyc);
        end
    endtask

    task automatic test_stale_done();
        int cyc; logic [NR-1:0] a; logic e; logic [CW-1:0] dm; int st;
        do_reset();
        set_max(3, 10'd0);
        model_d = 1;
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        wait_ack(40, cyc, a, e, dm, st);
        checks++; if (a !== 4'b1000 || e !== 1'b1 || cyc != 10) begin
            errors++; $display("FAIL stale_done_masked: got ack=%b err=%b cycles=%0d, expected 1000 1 10", a, e, cyc);
        end
    endtask

    task automatic test_max_count();
        int cyc; logic [NR-1:0] a; logic e; logic [CW-1:0] dm; int st;
        do_reset();
        set_max(0, 10'h3FF);
        model_d = 0;
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        set_max(0, 10'd7);
        wait_ack(1100, cyc, a, e, dm, st);
        checks++; if (a !== 4'b0001 || e !== 1'b1 || cyc != 1033) begin
            errors++; $display("FAIL max_timeout: got ack=%b err=%b cycles=%0d, expected 0001 1 1033", a, e, cyc);
        end
        checks++; if (dm !== 10'h3FF) begin
            errors++; $display("FAIL max_dly_max_held: got %0d, expected 1023", dm);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        req      = '0;
        req_max  = '0;
        model_d  = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_done_at_timeout();
        test_stale_done();
        test_max_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
